mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
- Memory stage of the 3-stage RISC-V pipeline. Consumes the execute-to-memory pipeline register outputs (`*M` signals).
- Performs loads and stores over a req/gnt/rvalid data-memory bus: store byte steering, load sign/zero extension, misalignment detection.
- Registers the writeback triple (data, rd, write enable) toward the register file.
- Stalls upstream stages while a bus transaction is outstanding.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- TIMEOUT_CYCLES, 255, watchdog limit; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- funct3M  in  3  access size/sign: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2.
- alu_outM  in  XLEN  effective address, or ALU result.
- forward_rs2M  in  XLEN  store data.
- jump_result_plus4M  in  XLEN  link value for JAL/JALR.
- opcodeM  in  7  LOAD=7'b0000011, STORE=7'b0100011.
- mem_accessM  in  1  instruction in M accesses memory.
- wb_selM  in  2  0=ALU, 1=MEM, 2=PC4.
- reg_writeM  in  1  instruction writes rd.
- rdM  in  5  destination register.
- dmem_req  out  1  bus request.
- dmem_we  out  1  1=store.
- dmem_addr  out  XLEN  word-aligned address ({alu_outM[31:2],2'b00}).
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_wstrb  out  4  byte strobes.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  XLEN  read data.
- stall  out  1  freeze fetch/execute and the EX/MEM register.
- wb_data  out  XLEN  registered writeback value.
- wb_rd  out  5  registered destination.
- wb_we  out  1  registered write enable.
- misalign  out  1  one-cycle pulse on a misaligned access.
- bus_err  out  1  one-cycle pulse on watchdog abort; tied 0 without LSU_TIMEOUT_EN.

Behaviour:
- Reset (async on rst_n low):
  - state=IDLE.
  - dmem_req, stall, wb_we, misalign, bus_err = 0.
  - wb_data=0, wb_rd=0.
  - Any outstanding request is abandoned; a late gnt/rvalid arriving after reset is ignored.
- FSM states: IDLE, WAIT_GNT, WAIT_RDATA.
- IDLE, memory op (mem_accessM=1, aligned):
  - Drive dmem_req=1 combinationally, with dmem_we=(opcodeM==STORE), addr, wdata and wstrb.
  - Store + gnt: retire this cycle, no stall.
  - Load + gnt + rvalid in the same cycle: retire.
  - Load + gnt only: go to WAIT_RDATA.
  - No gnt: go to WAIT_GNT.
- WAIT_GNT:
  - Hold req and all bus outputs stable until gnt.
  - Store: retire on gnt.
  - Load: retire on gnt+rvalid in the same cycle; gnt alone goes to WAIT_RDATA.
- WAIT_RDATA: retire on rvalid and return to IDLE. req=0.
- stall=1 whenever the instruction in M does not retire this cycle, i.e. in any non-IDLE state, or in IDLE with a memory op lacking completion. This is combinational.
- Misalignment:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0.
  - No bus request, misalign=1 for one cycle, wb_we=0, instruction retires immediately.
- Store steering:
  - SB: wdata={4{rs2[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, wstrb=addr[1] ? 4'b1100 : 4'b0011.
  - SW: wstrb=4'b1111.
- Load extraction: select byte/halfword by addr[1:0]; sign-extend for LB/LH, zero-extend for LBU/LHU.
- Writeback register (updated only on the retire cycle; otherwise wb_we=0 and wb_data/wb_rd hold):
  - wb_data = mux(wb_selM: ALU→alu_outM, MEM→extended load, PC4→jump_result_plus4M).
  - wb_rd = rdM.
  - wb_we = reg_writeM && rdM!=0 && !misalign && !abort.
- Non-memory instructions retire every cycle with zero added latency. Writeback is visible one cycle after M.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- With LSU_TIMEOUT_EN:
  - An 8-bit-or-wider counter runs in WAIT_GNT/WAIT_RDATA and clears on any state change.
  - Reaching TIMEOUT_CYCLES aborts: dmem_req=0, bus_err pulses one cycle, wb_we=0, return to IDLE, stall released.
- Without LSU_TIMEOUT_EN: no counter; waits indefinitely; bus_err constant 0.

Decomposition:
- Shared package/defines (alongside XLEN):
  - Opcode constants LOAD/STORE.
  - funct3 size codes.
  - wb_sel encodings WB_ALU/WB_MEM/WB_PC4.
  - FSM state encoding.
- One sub-module, lsu_align: purely combinational store steering/strobes and load extraction/extension, plus the misalign flag. It is reused by the FSM wrapper.

Test Plan:
- SW 0xDEADBEEF to 0x100, gnt same cycle → req=1, wstrb=4'b1111, wdata=0xDEADBEEF, stall=0, wb_we=0 next cycle.
- SB rs2=0x000000AB to 0x103, gnt after 2 cycles → wdata=0xABABABAB, wstrb=4'b1000, stall=1 for 2 cycles, bus outputs stable throughout.
- LH from 0x202 (rd=5), gnt immediate, rvalid with rdata=0x8001_1234 after 3 cycles → stall=1 for 3 cycles, then wb_data=0xFFFF8001, wb_rd=5, wb_we=1 for one cycle. LHU with the same stimulus → 0x00008001.
- LW to 0x101 → misalign pulse, dmem_req never asserted, wb_we=0, stall=0.
- ADD result 0x42 to rd=0 with reg_writeM=1 → wb_we=0. JAL to rd=1 with wb_sel=PC4, jump_result_plus4M=0x1004 → wb_data=0x1004, wb_we=1.
- rst_n low during WAIT_RDATA → stall/req drop immediately; a subsequent rvalid causes no writeback. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4 and no gnt → bus_err pulses after 4 cycles, stall released.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared constants for the memory-stage LSU: opcodes, access sizes, writeback
// select encodings and the bus FSM state type.
package mem_stage_lsu_pkg;

  localparam int unsigned LSU_XLEN = 32;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_GNT   = 2'd1,
    ST_WAIT_RDATA = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/gnt/rvalid bus between the memory stage (master) and the
// data memory or interconnect (slave).
interface mem_stage_lsu_if #(
  parameter int XLEN = 32
) ();
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_wstrb;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational byte-lane logic: store data replication and strobes, load
// byte/halfword extraction with sign/zero extension, and misalignment flag.
module lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    wdata      = store_data;
    wstrb      = 4'b1111;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      2'b01: begin
        wdata      = {2{store_data[15:0]}};
        wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      2'b10: misaligned = |addr_lo;
      default: ;
    endcase
  end

  always_comb begin
    load_byte = load_word[7:0];
    case (addr_lo)
      2'd1:    load_byte = load_word[15:8];
      2'd2:    load_byte = load_word[23:16];
      2'd3:    load_byte = load_word[31:24];
      default: load_byte = load_word[7:0];
    endcase
    load_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];

    load_data = load_word;
    case (funct3)
      F3_B:    load_data = {{24{load_byte[7]}}, load_byte};
      F3_H:    load_data = {{16{load_half[15]}}, load_half};
      F3_BU:   load_data = {24'd0, load_byte};
      F3_HU:   load_data = {16'd0, load_half};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage: drives the data bus, stalls upstream while a transaction is
// open, registers the writeback triple. Optional watchdog: LSU_TIMEOUT_EN.
//
// state         | meaning
// ST_IDLE       | no transaction open; instruction in M may issue or retire
// ST_WAIT_GNT   | request on the bus, waiting for gnt (outputs held)
// ST_WAIT_RDATA | load granted, waiting for rvalid
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN           = LSU_XLEN,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        funct3M,
  input  logic [XLEN-1:0]   alu_outM,
  input  logic [XLEN-1:0]   forward_rs2M,
  input  logic [XLEN-1:0]   jump_result_plus4M,
  input  logic [6:0]        opcodeM,
  input  logic              mem_accessM,
  input  logic [1:0]        wb_selM,
  input  logic              reg_writeM,
  input  logic [4:0]        rdM,
  mem_stage_lsu_if.master   bus,
  output logic              stall,
  output logic [XLEN-1:0]   wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_we,
  output logic              misalign,
  output logic              bus_err
);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_we_q, wb_we_d;
  logic            misalign_q, misalign_d;
  logic            bus_err_q, bus_err_d;

  logic            is_store, mis_flag, mis_c, mem_op;
  logic            req_c, retire, abort, tmo_hit;
  logic [31:0]     load_data;

  lsu_align u_align (
    .funct3     (funct3M),
    .addr_lo    (alu_outM[1:0]),
    .store_data (forward_rs2M),
    .load_word  (bus.dmem_rdata),
    .wdata      (bus.dmem_wdata),
    .wstrb      (bus.dmem_wstrb),
    .load_data  (load_data),
    .misaligned (mis_flag)
  );

  assign is_store = (opcodeM == OP_STORE);
  assign mis_c    = mem_accessM && mis_flag;
  assign mem_op   = mem_accessM && !mis_flag;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Down-counter reloaded on every state change; terminal count aborts the wait.
  assign tmo_hit = (state_q != ST_IDLE) && (tmo_cnt_q == '0);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_d != state_q)
      tmo_cnt_d = CNT_W'(TIMEOUT_CYCLES - 1);
    else if (state_q != ST_IDLE && tmo_cnt_q != '0)
      tmo_cnt_d = tmo_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= CNT_W'(TIMEOUT_CYCLES - 1);
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_tmo;
  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    retire  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          req_c = 1'b1;
          if (!bus.dmem_gnt)                        state_d = ST_WAIT_GNT;
          else if (is_store || bus.dmem_rvalid)     retire  = 1'b1;
          else                                      state_d = ST_WAIT_RDATA;
        end else begin
          retire = 1'b1;
        end
      end
      ST_WAIT_GNT: begin
        req_c = 1'b1;
        if (bus.dmem_gnt) begin
          if (is_store || bus.dmem_rvalid) begin
            retire  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_RDATA;
          end
        end
      end
      ST_WAIT_RDATA: begin
        if (bus.dmem_rvalid) begin
          retire  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (tmo_hit) begin
      req_c   = 1'b0;
      retire  = 1'b0;
      abort   = 1'b1;
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_we_d    = 1'b0;
    misalign_d = mis_c && (state_q == ST_IDLE);
    bus_err_d  = abort;
    if (retire) begin
      case (wb_selM)
        WB_MEM:  wb_data_d = load_data;
        WB_PC4:  wb_data_d = jump_result_plus4M;
        default: wb_data_d = alu_outM;
      endcase
      wb_rd_d = rdM;
      wb_we_d = reg_writeM && (rdM != 5'd0) && !mis_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_we_q    <= wb_we_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Reset silences the bus and releases the pipeline immediately, even while M still holds a memory op.
  assign bus.dmem_req  = req_c && rst_n;
  assign bus.dmem_we   = is_store;
  assign bus.dmem_addr = {alu_outM[XLEN-1:2], 2'b00};
  assign stall         = !(retire || abort) && rst_n;
  assign wb_data       = wb_data_q;
  assign wb_rd         = wb_rd_q;
  assign wb_we         = wb_we_q;
  assign misalign      = misalign_q;
  assign bus_err       = bus_err_q;

endmodule
